// File: rtl/sata_crc_scrambler_if.sv
// Link-layer bundle for sata_crc_scrambler: payload qualifier/data in, CRC and mask out.
// Optional CRC_FAULT_INJECT_EN adds the crc_fault control line.
interface sata_crc_scrambler_if;
  logic        data_valid;
  logic [31:0] data_in;
  logic [31:0] crc_out;
  logic [31:0] scrambler;

`ifdef CRC_FAULT_INJECT_EN
  logic        crc_fault;

  modport master (
    output data_valid, data_in, crc_fault,
    input  crc_out, scrambler
  );

  modport slave (
    input  data_valid, data_in, crc_fault,
    output crc_out, scrambler
  );
`else
  modport master (
    output data_valid, data_in,
    input  crc_out, scrambler
  );

  modport slave (
    input  data_valid, data_in,
    output crc_out, scrambler
  );
`endif
endinterface

// File: rtl/sata_crc_scrambler.sv
// SATA link-layer helper: running frame CRC-32 plus scrambler mask, one dword per qualified cycle.
// Optional macro CRC_FAULT_INJECT_EN: crc_fault inverts crc_out without touching state.
module sata_crc_scrambler #(
  parameter logic [31:0] C_CRC_INIT = 32'h5232_5032,
  parameter logic [31:0] C_CRC_POLY = 32'h04C1_1DB7,
  parameter logic [15:0] C_SCR_SEED = 16'hF0F6
) (
  input  logic                 clk_75m,
  input  logic                 crc_rst,
  sata_crc_scrambler_if.slave  bus
);

  logic [31:0] r_crc;
  logic [15:0] r_scr_state;
  logic [31:0] w_crc_next;
  logic [31:0] w_scr_mask;

  // Folding the dword into the register first lets 32 zero-input shifts replace
  // the per-bit data feedback; the loop unrolls into a flat XOR tree.
  function automatic logic [31:0] crc_dword(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] v;
    v = crc ^ data;
    // NOTE: blocking assignments are correct here; each iteration must see the previous one's result.
    for (int i = 0; i < 32; i++) begin
      v = {v[30:0], 1'b0} ^ (v[31] ? C_CRC_POLY : 32'h0);
    end
    return v;
  endfunction

  // State holds the 16 most recent sequence bits, bit 0 oldest; mask bit i is the
  // i-th newly generated bit, so the next state is simply mask[31:16].
  function automatic logic [31:0] scr_mask(input logic [15:0] state);
    logic [15:0] s;
    logic [31:0] m;
    logic        nb;
    s = state;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      nb   = s[15] ^ s[13] ^ s[4] ^ s[0];
      m[i] = nb;
      s    = {nb, s[15:1]};
    end
    return m;
  endfunction

  assign w_crc_next = crc_dword(r_crc, bus.data_in);
  assign w_scr_mask = scr_mask(r_scr_state);

  always_ff @(posedge clk_75m) begin
    if (crc_rst) begin
      r_crc       <= C_CRC_INIT;
      r_scr_state <= C_SCR_SEED;
    end else if (bus.data_valid) begin
      r_crc       <= w_crc_next;
      r_scr_state <= w_scr_mask[31:16];
    end
  end

  assign bus.scrambler = w_scr_mask;

`ifdef CRC_FAULT_INJECT_EN
  assign bus.crc_out = r_crc ^ {32{bus.crc_fault}};
`else
  assign bus.crc_out = r_crc;
`endif

endmodule

// File: tb/tb_sata_crc_scrambler.sv
// Scoreboard bench for sata_crc_scrambler: the driver queues the expected outputs of each
// cycle, a negedge monitor pops and compares them.
module tb_sata_crc_scrambler;

  localparam logic [31:0] INIT  = 32'h5232_5032;
  localparam logic [31:0] POLY  = 32'h04C1_1DB7;
  localparam logic [15:0] SEED  = 16'hF0F6;
  localparam logic [31:0] MASK0 = 32'hC2D2_768D;

  typedef struct {
    string       name;
    bit          chk_crc;
    bit          chk_scr;
    logic [31:0] exp_crc;
    logic [31:0] exp_scr;
  } exp_t;

  logic clk = 1'b0;
  logic crc_rst = 1'b0;
  sata_crc_scrambler_if bus ();

  sata_crc_scrambler dut (
    .clk_75m (clk),
    .crc_rst (crc_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_crc = '0;
  logic [15:0] m_scr = '0;
  bit          m_ok = 1'b0;
  logic [31:0] last_mask;

  logic [31:0] frame[8] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                            32'h8000_0001, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hCAFE_F00D};
  logic [31:0] ref_masks[4] = '{32'hC2D2_768D, 32'h1F26_B368, 32'hA508_436C, 32'h3452_D354};
  logic [31:0] clean_mask[8];
  logic [31:0] clean_crc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one data bit per step, MSB first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
    logic fb;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  // Sequence recurrence b[n] = b[n-1]^b[n-3]^b[n-12]^b[n-16]; bits [15:0] are the state.
  function automatic logic [47:0] ref_seq(input logic [15:0] st);
    logic [47:0] b;
    b = '0;
    b[15:0] = st;
    for (int n = 16; n < 48; n++) begin
      b[n] = b[n-1] ^ b[n-3] ^ b[n-12] ^ b[n-16];
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_crc) check({e.name, ".crc"}, bus.crc_out, e.exp_crc);
      if (e.chk_scr) check({e.name, ".scr"}, bus.scrambler, e.exp_scr);
    end
  end

  task automatic step(input bit rst, input bit vld, input logic [31:0] data, input bit flt,
                      input string name, input bit ov_crc, input logic [31:0] oc,
                      input bit ov_scr, input logic [31:0] os);
    exp_t        e;
    logic [47:0] seq;
    @(posedge clk);
    #1;
    crc_rst        = rst;
    bus.data_valid = vld;
    bus.data_in    = vld ? data : 32'hxxxx_xxxx;
`ifdef CRC_FAULT_INJECT_EN
    bus.crc_fault  = flt;
`endif
    seq       = ref_seq(m_scr);
    last_mask = seq[47:16];
    e.name    = name;
    e.chk_crc = ov_crc | m_ok;
    e.chk_scr = ov_scr | m_ok;
    e.exp_crc = ov_crc ? oc : (m_crc ^ {32{flt}});
    e.exp_scr = ov_scr ? os : seq[47:16];
    q.push_back(e);
    if (rst) begin
      m_crc = INIT;
      m_scr = SEED;
      m_ok  = 1'b1;
    end else if (vld) begin
      m_crc = ref_crc(m_crc, data);
      m_scr = seq[47:32];
    end
  endtask

  task automatic idle(input string name);
    step(1'b0, 1'b0, 32'h0, 1'b0, name, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic send(input logic [31:0] data, input string name);
    step(1'b0, 1'b1, data, 1'b0, name, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
`ifdef CRC_FAULT_INJECT_EN
    bus.crc_fault  = 1'b0;
`endif

    // Single reset pulse, then the reset values must hold while idle.
    step(1'b1, 1'b0, 32'h0, 1'b0, "reset", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, "idle_hold", 1'b1, INIT, 1'b1, MASK0);

    // Published mask sequence over four back-to-back dwords.
    step(1'b1, 1'b0, 32'h0, 1'b0, "rst2", 1'b1, INIT, 1'b1, MASK0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, frame[i], 1'b0, "mask_seq", 1'b0, 32'h0, 1'b1, ref_masks[i]);
    idle("after_masks");

    // Clean frame with idle gaps (data_in driven to X during gaps).
    step(1'b1, 1'b0, 32'h0, 1'b0, "rst3", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      send(frame[i], "gap_frame");
      clean_mask[i] = last_mask;
      idle("gap");
      if (i == 3) idle("gap2");
    end
    clean_crc = m_crc;
    idle("gap_frame_end");

    // Reset wins over data_valid in the same cycle.
    step(1'b1, 1'b1, 32'h1111_1111, 1'b0, "rst_vld", 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, "rst_prio", 1'b1, INIT, 1'b1, MASK0);

    // Abort after three dwords, reset, resend: must match the clean run.
    for (int i = 0; i < 3; i++) send(frame[i], "partial");
    step(1'b1, 1'b0, 32'h0, 1'b0, "mid_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, frame[i], 1'b0, "resend", 1'b0, 32'h0, 1'b1, clean_mask[i]);
    step(1'b0, 1'b0, 32'h0, 1'b0, "resend_crc", 1'b1, clean_crc, 1'b0, 32'h0);

`ifdef CRC_FAULT_INJECT_EN
    step(1'b0, 1'b0, 32'h0, 1'b1, "fault_on", 1'b1, ~clean_crc, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, "fault_hold", 1'b1, ~clean_crc, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fault_off", 1'b1, clean_crc, 1'b0, 32'h0);
`endif
    idle("final_hold");

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
